// File: rtl/subleq_memory.sv
// Word-addressed memory target for the SUBLEQ core's four-phase req/ack bus.
// Each access waits a fixed number of cycles, then holds a registered ack until req drops.
module subleq_memory #(
  parameter int WORD_BITS = 16,
  parameter int ADDR_BITS = 8,
  parameter int DEPTH     = 256,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic                 ack,
  output logic [WORD_BITS-1:0] rdata,
  output logic                 err
);

  localparam int          IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  LAT      = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   lat_we;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [WORD_BITS-1:0]   lat_wdata;

  logic                   acc_we;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [WORD_BITS-1:0]   acc_wdata;
  logic                   in_range;
  logic                   enter_ack;
  logic                   mem_wr;
  logic [IDX_BITS-1:0]    mem_idx;

  logic [WORD_BITS-1:0]   mem [0:DEPTH-1];

  // With zero latency the access happens on the accepting edge, so it uses the live bus.
  always_comb begin
    acc_we    = lat_we;
    acc_addr  = lat_addr;
    acc_wdata = lat_wdata;
    if (state == IDLE) begin
      acc_we    = we;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
  end

  generate
    if (DEPTH >= (2 ** ADDR_BITS)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_partial
      localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);
      assign in_range = {1'b0, acc_addr} < DEPTH_W;
    end
  endgenerate

  assign mem_idx   = acc_addr[IDX_BITS-1:0];
  assign enter_ack = ((state == IDLE) && req && (LAT == 4'd0)) ||
                     ((state == WAIT) && (cnt <= 4'd1));
  // Reset holds the FSM in IDLE, but a zero-latency request could still look like a commit.
  assign mem_wr    = enter_ack && acc_we && in_range && !areset;

  // NOTE: the array has no reset; clearing a RAM needs a sweep, and reset must keep contents anyway.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_idx] <= acc_wdata;
  end

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_we    <= we;
            lat_addr  <= addr;
            lat_wdata <= wdata;
            cnt       <= LAT;
            state     <= (LAT == 4'd0) ? ACK : WAIT;
          end
        end
        WAIT: begin
          cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
          if (cnt <= 4'd1) state <= ACK;
        end
        ACK: begin
          if (!req) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_ack) begin
        ack <= 1'b1;
        if (in_range) begin
          err   <= 1'b0;
          rdata <= acc_we ? acc_wdata : mem[mem_idx];
        end else begin
          err   <= 1'b1;
          rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_subleq_memory.sv
// Directed bench for subleq_memory: four instances cover DEPTH=200/256 and LATENCY=0/2/4/15.
module tb_subleq_memory;

  logic        clk = 1'b0;
  logic        areset;
  logic        we;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [15:0] rdata [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  subleq_memory #(.WORD_BITS(16), .ADDR_BITS(8), .DEPTH(200), .LATENCY(2)) u0 (
    .clk(clk), .areset(areset), .req(req[0]), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack[0]), .rdata(rdata[0]), .err(err[0]));
  subleq_memory #(.WORD_BITS(16), .ADDR_BITS(8), .DEPTH(256), .LATENCY(0)) u1 (
    .clk(clk), .areset(areset), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack[1]), .rdata(rdata[1]), .err(err[1]));
  subleq_memory #(.WORD_BITS(16), .ADDR_BITS(8), .DEPTH(256), .LATENCY(15)) u2 (
    .clk(clk), .areset(areset), .req(req[2]), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack[2]), .rdata(rdata[2]), .err(err[2]));
  subleq_memory #(.WORD_BITS(16), .ADDR_BITS(8), .DEPTH(256), .LATENCY(4)) u3 (
    .clk(clk), .areset(areset), .req(req[3]), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack[3]), .rdata(rdata[3]), .err(err[3]));

  // One full handshake on instance i. edges counts posedges from the accepting edge
  // up to the first one after which ack reads high; fell reports ack and err low one edge after req drops.
  task automatic access(input int i, input logic w, input logic [7:0] a, input logic [15:0] d,
                        input logic scramble, output logic [15:0] rd, output logic e,
                        output int edges, output logic fell);
    @(negedge clk);
    we = w; addr = a; wdata = d; req[i] = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (scramble && edges == 1) begin
        we = ~w; addr = ~a; wdata = ~d;
      end
    end while (!ack[i] && edges < 40);
    rd = rdata[i];
    e  = err[i];
    @(negedge clk);
    req[i] = 1'b0;
    @(posedge clk); #1;
    fell = !ack[i] && !err[i];
  endtask

  task automatic test_reset();
    logic [15:0] rd; logic e, fell; int edges;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (ack !== 4'b0000 || err !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: ack=%b err=%b want 0000/0000", ack, err);
    end
    n_cmp++;
    if (rdata[0] !== 16'h0000) begin
      n_bad++; $display("FAIL reset_rdata: got %h want 0000", rdata[0]);
    end
    @(negedge clk); areset = 1'b0;
    access(0, 1'b1, 8'h05, 16'h0000, 1'b0, rd, e, edges, fell);
    access(0, 1'b1, 8'h06, 16'h5555, 1'b0, rd, e, edges, fell);
    @(negedge clk); areset = 1'b1;
    #1;
    n_cmp++;
    if (rdata[0] !== 16'h0000) begin
      n_bad++; $display("FAIL reset_clears_rdata: got %h want 0000", rdata[0]);
    end
    @(negedge clk); areset = 1'b0;
    access(0, 1'b0, 8'h05, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (edges !== 3) begin
      n_bad++; $display("FAIL read_latency: got %0d edges want 3", edges);
    end
    n_cmp++;
    if (rd !== 16'h0000 || e !== 1'b0) begin
      n_bad++; $display("FAIL read_after_reset: rdata=%h err=%b want 0000/0", rd, e);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic e, fell; int edges;
    access(0, 1'b1, 8'h10, 16'h1234, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h1234 || fell !== 1'b1) begin
      n_bad++; $display("FAIL write_ack: rdata=%h fell=%b want 1234/1", rd, fell);
    end
    access(0, 1'b0, 8'h10, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h1234 || e !== 1'b0) begin
      n_bad++; $display("FAIL read_back: rdata=%h err=%b want 1234/0", rd, e);
    end
    n_cmp++;
    if (fell !== 1'b1 || edges !== 3) begin
      n_bad++; $display("FAIL read_back_timing: fell=%b edges=%0d want 1/3", fell, edges);
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] rd; logic e, fell; int edges;
    access(0, 1'b1, 8'hC7, 16'h7777, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (e !== 1'b0) begin
      n_bad++; $display("FAIL last_in_range_err: got %b want 0", e);
    end
    access(0, 1'b1, 8'h48, 16'h4848, 1'b0, rd, e, edges, fell);
    access(0, 1'b1, 8'hC8, 16'hBEEF, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (e !== 1'b1 || rd !== 16'h0000) begin
      n_bad++; $display("FAIL oor_write: err=%b rdata=%h want 1/0000", e, rd);
    end
    n_cmp++;
    if (fell !== 1'b1) begin
      n_bad++; $display("FAIL oor_err_clear: ack/err low after drop got %b want 1", fell);
    end
    access(0, 1'b0, 8'hC8, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (e !== 1'b1 || rd !== 16'h0000) begin
      n_bad++; $display("FAIL oor_read: err=%b rdata=%h want 1/0000", e, rd);
    end
    access(0, 1'b0, 8'hC7, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h7777 || e !== 1'b0) begin
      n_bad++; $display("FAIL oor_neighbour: rdata=%h err=%b want 7777/0", rd, e);
    end
    access(0, 1'b0, 8'h48, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h4848) begin
      n_bad++; $display("FAIL oor_alias: rdata=%h want 4848", rd);
    end
  endtask

  task automatic test_latency_sweep();
    logic [15:0] rd; logic e, fell; int edges;
    access(1, 1'b1, 8'hFF, 16'hA5A5, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (edges !== 1 || e !== 1'b0) begin
      n_bad++; $display("FAIL lat0_write: edges=%0d err=%b want 1/0", edges, e);
    end
    access(1, 1'b0, 8'hFF, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'hA5A5 || edges !== 1 || fell !== 1'b1) begin
      n_bad++; $display("FAIL lat0_read: rdata=%h edges=%0d fell=%b want A5A5/1/1", rd, edges, fell);
    end
    access(2, 1'b1, 8'hCC, 16'h1111, 1'b0, rd, e, edges, fell);
    access(2, 1'b1, 8'h33, 16'h0F0F, 1'b1, rd, e, edges, fell);
    n_cmp++;
    if (edges !== 16) begin
      n_bad++; $display("FAIL lat15_latency: got %0d edges want 16", edges);
    end
    n_cmp++;
    if (rd !== 16'h0F0F) begin
      n_bad++; $display("FAIL lat15_scramble_rdata: got %h want 0F0F", rd);
    end
    access(2, 1'b0, 8'h33, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h0F0F) begin
      n_bad++; $display("FAIL lat15_readback: got %h want 0F0F", rd);
    end
    access(2, 1'b0, 8'hCC, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h1111) begin
      n_bad++; $display("FAIL lat15_scramble_addr: got %h want 1111", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic e, fell; int edges;
    access(3, 1'b1, 8'h20, 16'h0055, 1'b0, rd, e, edges, fell);
    @(negedge clk);
    we = 1'b1; addr = 8'h20; wdata = 16'h00AA; req[3] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    areset = 1'b1;
    #1;
    n_cmp++;
    if (ack[3] !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_wait_ack: got %b want 0", ack[3]);
    end
    req[3] = 1'b0;
    @(negedge clk); areset = 1'b0;
    access(3, 1'b0, 8'h20, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h0055) begin
      n_bad++; $display("FAIL reset_in_wait_discard: got %h want 0055", rd);
    end
    @(negedge clk);
    we = 1'b1; addr = 8'h21; wdata = 16'h00BB; req[3] = 1'b1;
    edges = 0;
    do begin
      @(posedge clk); #1; edges++;
    end while (!ack[3] && edges < 40);
    n_cmp++;
    if (ack[3] !== 1'b1 || edges !== 5) begin
      n_bad++; $display("FAIL lat4_ack: ack=%b edges=%0d want 1/5", ack[3], edges);
    end
    #2 areset = 1'b1;
    #1;
    n_cmp++;
    if (ack[3] !== 1'b0 || rdata[3] !== 16'h0000) begin
      n_bad++; $display("FAIL reset_in_ack: ack=%b rdata=%h want 0/0000", ack[3], rdata[3]);
    end
    req[3] = 1'b0;
    @(negedge clk); areset = 1'b0;
    access(3, 1'b0, 8'h21, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'h00BB) begin
      n_bad++; $display("FAIL reset_in_ack_keep: got %h want 00BB", rd);
    end
  endtask

  task automatic test_subleq();
    logic [15:0] rd, a_ptr, a_val, b_ptr, b_val, c_val, stored; logic e, fell; int edges;
    int acks = 0;
    access(0, 1'b1, 8'h00, 16'h0030, 1'b0, rd, e, edges, fell);
    access(0, 1'b1, 8'h01, 16'h0031, 1'b0, rd, e, edges, fell);
    access(0, 1'b1, 8'h02, 16'h0007, 1'b0, rd, e, edges, fell);
    access(0, 1'b1, 8'h30, 16'h0005, 1'b0, rd, e, edges, fell);
    access(0, 1'b1, 8'h31, 16'h0003, 1'b0, rd, e, edges, fell);
    // Controller model: fetch A, deref A, fetch B, deref B, store, fetch C.
    access(0, 1'b0, 8'h00, 16'h0000, 1'b0, a_ptr, e, edges, fell);
    if (edges == 3 && fell) acks++;
    access(0, 1'b0, a_ptr[7:0], 16'h0000, 1'b0, a_val, e, edges, fell);
    if (edges == 3 && fell) acks++;
    access(0, 1'b0, 8'h01, 16'h0000, 1'b0, b_ptr, e, edges, fell);
    if (edges == 3 && fell) acks++;
    access(0, 1'b0, b_ptr[7:0], 16'h0000, 1'b0, b_val, e, edges, fell);
    if (edges == 3 && fell) acks++;
    access(0, 1'b1, b_ptr[7:0], b_val - a_val, 1'b0, stored, e, edges, fell);
    if (edges == 3 && fell) acks++;
    access(0, 1'b0, 8'h02, 16'h0000, 1'b0, c_val, e, edges, fell);
    if (edges == 3 && fell) acks++;
    n_cmp++;
    if (acks !== 6) begin
      n_bad++; $display("FAIL subleq_acks: got %0d want 6", acks);
    end
    n_cmp++;
    if (stored !== 16'hFFFE || c_val !== 16'h0007) begin
      n_bad++; $display("FAIL subleq_values: store=%h c=%h want FFFE/0007", stored, c_val);
    end
    access(0, 1'b0, 8'h31, 16'h0000, 1'b0, rd, e, edges, fell);
    n_cmp++;
    if (rd !== 16'hFFFE) begin
      n_bad++; $display("FAIL subleq_readback: got %h want FFFE", rd);
    end
  endtask

  initial begin
    areset = 1'b1;
    req    = 4'b0000;
    we     = 1'b0;
    addr   = 8'h00;
    wdata  = 16'h0000;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_latency_sweep();
    test_reset_mid();
    test_subleq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
